// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared defaults and types for the register-file scoreboard
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 8;
  localparam bit DEF_ZERO_REG0 = 1'b0;

  typedef logic [DEF_DATA_W-1:0]       data_t;
  typedef logic [$clog2(DEF_DEPTH)-1:0] addr_t;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// reg_scoreboard : per-register busy flags set by claims, cleared by writes
// Revision       : 1.0
// ============================================================================
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  bit ZERO_REG0 = DEF_ZERO_REG0,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;

  // Claim is applied after the clear so a same-cycle claim+write leaves the
  // register busy: a new producer is already in flight.
  always_comb begin
    w_busy_next = r_busy;
    if (wr_en)
      w_busy_next[wr_addr] = 1'b0;
    if (claim_en)
      w_busy_next[claim_addr] = 1'b1;
    if (ZERO_REG0)
      w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_busy <= '0;
    else
      r_busy <= w_busy_next;
  end

  always_comb begin
    busy_a = r_busy[rd_addr_a] & ~(wr_en && (wr_addr == rd_addr_a));
    busy_b = r_busy[rd_addr_b] & ~(wr_en && (wr_addr == rd_addr_b));
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// reg_file_scoreboard : 2R/1W register file with write bypass, optional
//                       hardwired-zero R0 and a RAW-hazard busy scoreboard
// Revision            : 1.0
// ============================================================================
module reg_file_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  bit ZERO_REG0 = DEF_ZERO_REG0,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              hazard
);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_wr_ok;

  assign w_wr_ok = wr_en && !(ZERO_REG0 && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Bypass first, then R0 masking so a hardwired zero overrides the bypass.
  always_comb begin
    rd_data_a = r_regs[rd_addr_a];
    if (wr_en && (wr_addr == rd_addr_a))
      rd_data_a = wr_data;
    if (ZERO_REG0 && (rd_addr_a == '0))
      rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = r_regs[rd_addr_b];
    if (wr_en && (wr_addr == rd_addr_b))
      rd_data_b = wr_data;
    if (ZERO_REG0 && (rd_addr_b == '0))
      rd_data_b = '0;
  end

  reg_scoreboard #(
    .DEPTH     (DEPTH),
    .ZERO_REG0 (ZERO_REG0)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .busy_a     (busy_a),
    .busy_b     (busy_b)
  );

  assign hazard = busy_a | busy_b;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_reg_file_scoreboard : bench for reg_file_scoreboard, ZERO_REG0=0 and =1
// Revision               : 1.0
// ============================================================================
module tb_reg_file_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] ra, rb;
  logic       claim_en;
  logic [2:0] claim_addr;

  logic [7:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic       busy_a0, busy_b0, haz0, busy_a1, busy_b1, haz1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: index 0 models ZERO_REG0=0, index 1 models ZERO_REG0=1
  logic [7:0] m_regs [2][8];
  logic       m_busy [2][8];

  always #5 clk = ~clk;

  reg_file_scoreboard #(.DATA_W(8), .DEPTH(8), .ZERO_REG0(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rd_a0), .rd_data_b(rd_b0),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_a(busy_a0), .busy_b(busy_b0), .hazard(haz0)
  );

  reg_file_scoreboard #(.DATA_W(8), .DEPTH(8), .ZERO_REG0(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rd_a1), .rd_data_b(rd_b1),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_a(busy_a1), .busy_b(busy_b1), .hazard(haz1)
  );

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       ce;
    logic [2:0] ca;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       eba;
    logic       ebb;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] exp_rd(input int z, input logic [2:0] a);
    if (z == 1 && a == 3'd0) return 8'h00;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[z][a];
  endfunction

  function automatic logic exp_busy(input int z, input logic [2:0] a);
    if (z == 1 && a == 3'd0) return 1'b0;
    return m_busy[z][a] && !(wr_en && wr_addr == a);
  endfunction

  task automatic model_reset();
    for (int z = 0; z < 2; z++)
      for (int r = 0; r < 8; r++) begin
        m_regs[z][r] = 8'h00;
        m_busy[z][r] = 1'b0;
      end
  endtask

  task automatic model_update();
    for (int z = 0; z < 2; z++) begin
      if (wr_en && !(z == 1 && wr_addr == 3'd0)) begin
        m_regs[z][wr_addr] = wr_data;
        m_busy[z][wr_addr] = 1'b0;
      end
      if (claim_en && !(z == 1 && claim_addr == 3'd0))
        m_busy[z][claim_addr] = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("m0_rd_a", rd_a0, exp_rd(0, ra));
    chk("m0_rd_b", rd_b0, exp_rd(0, rb));
    chk("m0_busy_a", busy_a0, exp_busy(0, ra));
    chk("m0_busy_b", busy_b0, exp_busy(0, rb));
    chk("m0_hazard", haz0, exp_busy(0, ra) | exp_busy(0, rb));
    chk("m1_rd_a", rd_a1, exp_rd(1, ra));
    chk("m1_rd_b", rd_b1, exp_rd(1, rb));
    chk("m1_busy_a", busy_a1, exp_busy(1, ra));
    chk("m1_busy_b", busy_b1, exp_busy(1, rb));
    chk("m1_hazard", haz1, exp_busy(1, ra) | exp_busy(1, rb));
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs checked at the falling edge.
  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    if (rst) model_update();
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic ce, input logic [2:0] ca,
                       input logic [2:0] a, input logic [2:0] b);
    wr_en = we; wr_addr = wa; wr_data = wd;
    claim_en = ce; claim_addr = ca; ra = a; rb = b;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'd0, 8'hAA, 1'b0, 3'd0, 3'd0, 3'd7, 8'hAA, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd7, 8'hF0, 1'b0, 3'd0, 3'd0, 3'd7, 8'hAA, 8'hF0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd7, 8'hAA, 8'hF0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'd3, 8'h5C, 1'b0, 3'd0, 3'd3, 3'd3, 8'h5C, 8'h5C, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 3'd3, 8'h00, 8'h5C, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd2, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 3'd2, 3'd7, 8'h11, 8'hF0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd2, 8'h11, 8'h11, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 3'd4, 8'h3E, 1'b1, 3'd4, 3'd4, 3'd4, 8'h3E, 8'h3E, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd0, 8'h3E, 8'hAA, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 3'd5, 8'h77, 1'b1, 3'd4, 3'd4, 3'd5, 8'h3E, 8'h77, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd5, 8'h3E, 8'h77, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 3'd4, 8'h01, 1'b0, 3'd0, 3'd4, 3'd5, 8'h01, 8'h77, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd4, 8'h01, 8'h01, 1'b0, 1'b0};

    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset held: every register reads zero and nothing is busy
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(7 - i);
      #2;
      chk("reset_rd_a", rd_a0, 8'h00);
      chk("reset_rd_b", rd_b0, 8'h00);
      chk("reset_busy", {busy_a0, busy_b0, haz0, busy_a1, busy_b1, haz1}, 6'b0);
      check_model();
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed table on the ZERO_REG0=0 instance, model checks both
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ce, vecs[i].ca, vecs[i].ra, vecs[i].rb);
      @(negedge clk);
      chk($sformatf("vec%0d_rd_a", i), rd_a0, vecs[i].ea);
      chk($sformatf("vec%0d_rd_b", i), rd_b0, vecs[i].eb);
      chk($sformatf("vec%0d_busy_a", i), busy_a0, vecs[i].eba);
      chk($sformatf("vec%0d_busy_b", i), busy_b0, vecs[i].ebb);
      chk($sformatf("vec%0d_hazard", i), haz0, vecs[i].eba | vecs[i].ebb);
      check_model();
      @(posedge clk);
      model_update();
      #1;
    end

    // Write and claim R0 together: hardwired zero ignores both, ordinary R0 takes both
    drive(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    chk("z1_r0_bypass_rd", rd_a1, 8'h00);
    chk("z1_r0_bypass_busy", busy_a1, 1'b0);
    chk("z0_r0_bypass_rd", rd_a0, 8'hFF);
    @(posedge clk);
    model_update();
    #1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    chk("z1_r0_after_rd", rd_b1, 8'h00);
    chk("z1_r0_after_busy", haz1, 1'b0);
    chk("z0_r0_after_rd", rd_a0, 8'hFF);
    chk("z0_r0_after_busy", busy_a0, 1'b1);
    @(posedge clk);
    #1;

    // Write burst interrupted by reset: contents vanish without a clock edge
    for (int i = 1; i < 7; i++) begin
      drive(1'b1, 3'(i), 8'(8'h20 + i), 1'b1, 3'(7 - i), 3'(i - 1), 3'd6);
      cycle();
    end
    rst = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd1);
    model_reset();
    #1;
    chk("midrst_rd_a", rd_a0, 8'h00);
    chk("midrst_rd_b", rd_b1, 8'h00);
    chk("midrst_busy", {haz0, haz1}, 2'b00);
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(i ^ 3);
      #1;
      check_model();
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 3'd6, 8'h42, 1'b0, 3'd0, 3'd6, 3'd5);
    cycle();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd5);
    @(negedge clk);
    chk("post_rst_write", rd_a0, 8'h42);
    chk("post_rst_other", rd_b0, 8'h00);
    @(posedge clk);
    #1;

    // Random traffic with occasional asynchronous reset pulses
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 49) != 0);
      if (!rst) begin
        drive(1'b0, 3'(4'($urandom_range(0, 7))), 8'h00, 1'b0, 3'd0,
              3'(4'($urandom_range(0, 7))), 3'(4'($urandom_range(0, 7))));
        model_reset();
      end else begin
        drive(1'($urandom_range(0, 1)), 3'(4'($urandom_range(0, 7))), 8'($urandom),
              1'($urandom_range(0, 2) == 0), 3'(4'($urandom_range(0, 7))),
              3'(4'($urandom_range(0, 7))), 3'(4'($urandom_range(0, 7))));
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
